// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
//
// Multi-channel, run-time-programmable tick generator. Each channel divides
// the system clock by its own period register and emits a one-cycle strobe
// at every terminal count. A channel can run periodically or fire once and
// park in DONE. The period can be rewritten while the channel is running,
// for example to speed up gravity as the level rises.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   resetn       asynchronous, active-low reset
//   enable       per-channel run enable (level); low forces IDLE
//   oneshot      per-channel mode, 1 = one-shot, 0 = periodic
//   restart      per-channel synchronous restart strobe
//   pause        global freeze of all running counters
//   period_wr    period write strobe
//   period_sel   channel addressed by period_wr (out-of-range ignored)
//   period_data  new period in clk cycles (0 = never tick)
//   tick         registered one-cycle tick strobe per channel
//   active       channel is in RUN
//   done         one-shot channel has fired and is in DONE
// ---------------------------------------------------------------------------
module tick_gen_multi #(
  parameter int                          NUM_CH     = 3,
  parameter int                          CNT_W      = 26,
  parameter logic [NUM_CH*CNT_W-1:0]     DEF_PERIOD = {26'd12500000, 26'd50000000, 26'd833334},
  localparam int                         SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic [NUM_CH-1:0] restart,
  input  logic              pause,
  input  logic              period_wr,
  input  logic [SEL_W-1:0]  period_sel,
  input  logic [CNT_W-1:0]  period_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            st_q  [NUM_CH];
  state_t            st_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  per_q [NUM_CH];
  logic [CNT_W-1:0]  per_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;

  // Terminal count uses >= so that shrinking the period below the current
  // count fires on the next active edge instead of wrapping through the
  // full counter range. Caller guarantees per != 0.
  function automatic logic is_terminal(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] per);
    return (cnt >= (per - CNT_ONE));
  endfunction

  // Next-state, counter and strobe logic, one independent channel per loop
  // iteration. The period register is written from the bus; the compare
  // below always sees the value held before this edge.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      per_d[i]  = per_q[i];
      tick_d[i] = 1'b0;

      if (period_wr && (int'(period_sel) == i)) begin
        per_d[i] = period_data;
      end

      if (!enable[i]) begin
        st_d[i]  = ST_IDLE;
        cnt_d[i] = '0;
      end else if (restart[i]) begin
        // Restart beats a coincident terminal count and ignores pause.
        st_d[i]  = ST_RUN;
        cnt_d[i] = '0;
      end else begin
        unique case (st_q[i])
          ST_IDLE: begin
            st_d[i]  = ST_RUN;
            cnt_d[i] = '0;
          end
          ST_RUN: begin
            if (pause || (per_q[i] == '0)) begin
              cnt_d[i] = cnt_q[i];
            end else if (is_terminal(cnt_q[i], per_q[i])) begin
              tick_d[i] = 1'b1;
              cnt_d[i]  = '0;
              if (oneshot[i]) begin
                st_d[i] = ST_DONE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          ST_DONE: begin
            st_d[i] = ST_DONE;
          end
          default: begin
            st_d[i]  = ST_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
        per_q[i] <= DEF_PERIOD[i*CNT_W +: CNT_W];
      end
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        per_q[i] <= per_d[i];
      end
      tick_q <= tick_d;
    end
  end

  // Status levels decode directly from the state flops, so they drop with
  // the asynchronous reset just like tick.
  always_comb begin
    active = '0;
    done   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (st_q[i] == ST_RUN);
      done[i]   = (st_q[i] == ST_DONE);
    end
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_tick_gen_multi
//
// Directed bench for tick_gen_multi with NUM_CH = 3, CNT_W = 8 and reset
// periods ch0 = 4, ch1 = 5, ch2 = 6. Edge numbers in the comments count
// from the edge that first samples the channel enable (edge 0).
// ---------------------------------------------------------------------------
module tb_tick_gen_multi;

  logic       clk;
  logic       resetn;
  logic [2:0] enable;
  logic [2:0] oneshot;
  logic [2:0] restart;
  logic       pause;
  logic       period_wr;
  logic [1:0] period_sel;
  logic [7:0] period_data;
  logic [2:0] tick;
  logic [2:0] active;
  logic [2:0] done;

  int n_pass  = 0;
  int n_total = 0;

  tick_gen_multi #(
    .NUM_CH     (3),
    .CNT_W      (8),
    .DEF_PERIOD ({8'd6, 8'd5, 8'd4})
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .oneshot     (oneshot),
    .restart     (restart),
    .pause       (pause),
    .period_wr   (period_wr),
    .period_sel  (period_sel),
    .period_data (period_data),
    .tick        (tick),
    .active      (active),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    resetn      = 1'b0;
    enable      = 3'b000;
    oneshot     = 3'b000;
    restart     = 3'b000;
    pause       = 1'b0;
    period_wr   = 1'b0;
    period_sel  = 2'd0;
    period_data = 8'd0;

    // Reset state
    #12;
    check("rst_tick",   tick,   3'b000);
    check("rst_active", active, 3'b000);
    check("rst_done",   done,   3'b000);

    // Periodic: ch0 every 4, ch1 every 5, ch2 every 6
    resetn = 1'b1;
    enable = 3'b111;
    step();
    check("per_active_e0", active, 3'b111);
    check("per_tick_e0",   tick,   3'b000);
    for (int e = 1; e <= 13; e++) begin
      step();
      check($sformatf("per_tick_e%0d", e), tick,
            {(e % 6) == 0, (e % 5) == 0, (e % 4) == 0});
    end

    // One-shot on ch1
    enable = 3'b000;
    step();
    check("os_idle_active", active, 3'b000);
    oneshot = 3'b010;
    enable  = 3'b010;
    step();
    check("os_active_e0", active, 3'b010);
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("os_tick_e%0d", e), tick, (e == 5) ? 3'b010 : 3'b000);
    end
    check("os_done",   done,   3'b010);
    check("os_active", active, 3'b000);
    step();
    check("os_hold_tick", tick, 3'b000);
    check("os_hold_done", done, 3'b010);
    restart = 3'b010;
    step();
    restart = 3'b000;
    check("os_rs_active", active, 3'b010);
    check("os_rs_done",   done,   3'b000);
    check("os_rs_tick",   tick,   3'b000);
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("os_rs_tick_e%0d", e), tick, (e == 5) ? 3'b010 : 3'b000);
    end
    check("os_rs_done2", done, 3'b010);

    // Pause on ch0 for 3 cycles starting at cnt = 2
    enable  = 3'b000;
    oneshot = 3'b000;
    step();
    enable = 3'b001;
    step();
    step();
    step();
    check("pz_pre_tick", tick, 3'b000);
    pause = 1'b1;
    for (int e = 3; e <= 5; e++) begin
      step();
      check($sformatf("pz_hold_e%0d", e), tick, 3'b000);
    end
    pause = 1'b0;
    for (int e = 6; e <= 15; e++) begin
      step();
      check($sformatf("pz_tick_e%0d", e), tick,
            (e == 7 || e == 11 || e == 15) ? 3'b001 : 3'b000);
    end

    // Period shrink on ch1: write 2 at cnt = 3, then write 0
    enable = 3'b000;
    step();
    enable = 3'b010;
    step();
    for (int e = 1; e <= 3; e++) begin
      step();
      check($sformatf("sh_pre_e%0d", e), tick, 3'b000);
    end
    period_wr   = 1'b1;
    period_sel  = 2'd1;
    period_data = 8'd2;
    step();
    period_wr = 1'b0;
    check("sh_wr_tick", tick, 3'b000);
    for (int e = 5; e <= 11; e++) begin
      step();
      check($sformatf("sh_tick_e%0d", e), tick, (e % 2 == 1) ? 3'b010 : 3'b000);
    end
    period_wr   = 1'b1;
    period_data = 8'd0;
    step();
    period_wr = 1'b0;
    check("sh_zero_wr_tick", tick, 3'b000);
    for (int e = 13; e <= 20; e++) begin
      step();
      check($sformatf("sh_zero_tick_e%0d", e), tick, 3'b000);
    end
    check("sh_zero_active", active, 3'b010);

    // Restart on the terminal edge of ch0
    enable = 3'b000;
    step();
    enable = 3'b001;
    step();
    step();
    step();
    step();
    restart = 3'b001;
    step();
    restart = 3'b000;
    check("pr_rs_term_tick",   tick,   3'b000);
    check("pr_rs_term_active", active, 3'b001);
    for (int e = 5; e <= 8; e++) begin
      step();
      check($sformatf("pr_tick_e%0d", e), tick, (e == 8) ? 3'b001 : 3'b000);
    end
    // enable low beats restart
    enable  = 3'b000;
    restart = 3'b001;
    step();
    restart = 3'b000;
    check("pr_en_rs_active", active, 3'b000);
    check("pr_en_rs_tick",   tick,   3'b000);

    // Reprogram ch0 to 7, run ch0 periodic and ch2 one-shot, then reset
    period_wr   = 1'b1;
    period_sel  = 2'd0;
    period_data = 8'd7;
    step();
    period_wr = 1'b0;
    check("rs_idle_active", active, 3'b000);
    enable  = 3'b101;
    oneshot = 3'b100;
    step();
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("rs_tick_e%0d", e), tick,
            (e == 6) ? 3'b100 : ((e == 7) ? 3'b001 : 3'b000));
    end
    check("rs_pre_done",   done,   3'b100);
    check("rs_pre_active", active, 3'b001);
    #3;
    resetn = 1'b0;
    #1;
    check("rs_async_tick",   tick,   3'b000);
    check("rs_async_active", active, 3'b000);
    check("rs_async_done",   done,   3'b000);
    enable  = 3'b001;
    oneshot = 3'b000;
    #2;
    resetn = 1'b1;
    step();
    check("rs_rel_active", active, 3'b001);
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("rs_def_tick_e%0d", e), tick, (e == 4) ? 3'b001 : 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

- Multi-channel, run-time-programmable tick generator for the game's timing: 60 Hz frame tick, 1 s tick, gravity/drop tick.
- Each channel is an independent down-divided pulse source from the 50 MHz system clock.
- Each channel has an enable, a one-shot or periodic mode, a synchronous restart, a global pause, and a period register writable while running. Level logic can therefore speed up gravity without a rebuild.
- Sits between the system clock and the game FSM / renderer; all outputs are one-cycle strobes or levels in the `clk` domain.

## Interface
- NUM_CH, 3, number of independent channels (1..8)
- CNT_W, 26, counter and period width in bits
- DEF_PERIOD, {26'd12500000, 26'd50000000, 26'd833334}, packed NUM_CH*CNT_W reset periods in cycles; channel 0 in LSBs (ch0 = 60 Hz, ch1 = 1 s, ch2 = 0.25 s at 50 MHz)
- clk  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- enable  in  NUM_CH  per-channel run enable (level)
- oneshot  in  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic; sampled at each terminal count
- restart  in  NUM_CH  per-channel synchronous restart strobe
- pause  in  1  global freeze of all counters
- period_wr  in  1  period write strobe
- period_sel  in  $clog2(NUM_CH) (min 1)  channel addressed by period_wr; out-of-range values are ignored
- period_data  in  CNT_W  new period in cycles
- tick  out  NUM_CH  registered one-cycle tick strobe per channel
- active  out  NUM_CH  channel is in RUN
- done  out  NUM_CH  one-shot channel has fired and is in DONE

## Operation
- Per channel: period register `per`, counter `cnt` (CNT_W bits), state IDLE / RUN / DONE.
- Reset (async, resetn = 0):
  - state = IDLE, cnt = 0, per = DEF_PERIOD slice
  - tick, active, done = 0
- Transitions, highest priority first:
  1. enable = 0 → IDLE, cnt = 0. Applies in any state, even with restart or pause asserted.
  2. restart = 1 → RUN, cnt = 0, no tick that edge. Works from RUN and DONE; not gated by pause.
  3. IDLE with enable = 1 → RUN, cnt = 0.
  4. RUN with pause = 1 → hold cnt; tick = 0.
  5. RUN with per = 0 → hold; never ticks.
  6. RUN, cnt >= per−1 (terminal count) → tick = 1, cnt = 0; then DONE if oneshot = 1, else stay in RUN.
  7. RUN otherwise → cnt + 1.
  8. DONE → hold until enable = 0 or restart.
- Terminal compare is `>=`, not `==`. If per is written below the current cnt, the channel ticks on its next active edge instead of wrapping.
- Period write: on an edge with period_wr = 1, `per[period_sel]` ← period_data.
  - The new value is used by the compare from the following edge.
  - cnt is not cleared.
  - A write to a DONE or IDLE channel only changes `per`.
- tick is 0 on every edge where rule 6 does not fire; it is never high two cycles in a row unless per = 1.
- Outputs: active = (state == RUN), done = (state == DONE); both registered.

## Timing
- First tick: enable is sampled high at edge E0 (IDLE→RUN). tick is high for the cycle after edge E0+per, given no pause.
- Periodic spacing: exactly per cycles between tick rising edges. per = 1 gives tick continuously high.
- Pause for k active cycles delays all subsequent ticks by exactly k cycles. No tick is lost or duplicated.
- Restart at edge R: next tick at edge R+per.
- Restart on the same edge as a terminal count: restart wins and no tick is issued.
- enable dropped mid-count: tick = 0 from the next edge. Re-enable starts a full new period.
- resetn asserted mid-operation: all outputs drop immediately, asynchronously. The first edge after release behaves as rule 3.
- Channels are fully independent; simultaneous ticks on several channels are legal.

## Test plan
- Bench config: NUM_CH = 3, CNT_W = 8, DEF_PERIOD = {8'd6, 8'd5, 8'd4}.
- Reset and periodic: release resetn, enable = 3'b111 at edge 0 → ch0 ticks at edges 4, 8, 12; ch1 at 5, 10; ch2 at 6, 12. ch0 and ch2 tick together at edge 12. Each tick is one cycle wide.
- One-shot: oneshot[1] = 1, enable[1] = 1 → single tick at edge 5, then done[1] = 1 and active[1] = 0. restart[1] pulse → active = 1 and tick 5 edges later.
- Pause: ch0 running, pause high for 3 cycles starting at cnt = 2 → the tick lands 3 cycles late; the following ticks keep 4-cycle spacing.
- Period shrink: ch1 at cnt = 3; write period_sel = 1, period_data = 2 → tick on the next edge, then every 2 cycles. Write period_data = 0 → no further ticks while active[1] stays 1.
- Priority and reset: assert restart[0] on the terminal edge → no tick, next tick 4 edges later. Drop enable[0] together with restart[0] → IDLE. Assert resetn = 0 mid-count → tick, active and done go to 0 without a clock edge, and the period reverts to 4.
